// File: rtl/thermometer_ramp.sv
// LED bar-graph driver: steps a displayed level toward the target one LED per
// prescaler tick and drives a peak-hold marker that holds, then decays.
module thermometer_ramp #(
  parameter int unsigned K          = 3,
  parameter int unsigned W          = 2**K - 1,
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] target,
  output logic [K-1:0] level,
  output logic [W-1:0] bar,
  output logic [W-1:0] peak,
  output logic         busy,
  output logic         tick
);

  localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_TICKS);
  localparam logic [K-1:0]     LevelMax = K'(W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [DivW-1:0]  r_div_cnt;
  logic             r_tick;
  logic [K-1:0]     r_level;
  logic [K-1:0]     r_peak_val;
  logic [HoldW-1:0] r_hold_cnt;
  logic [1:0]       r_state;

  logic [1:0]       w_state_nxt;
  logic [K-1:0]     w_level_nxt;

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (target > r_level) begin
      w_state_nxt = ST_UP;
    end else if (target < r_level) begin
      w_state_nxt = ST_DOWN;
    end
  end

  // Direction comes from the registered state; the live compare only blocks a
  // step that would pass the target or leave 0..W.
  always_comb begin
    w_level_nxt = r_level;
    if (r_tick) begin
      case (r_state)
        ST_UP:   if (r_level < target && r_level != LevelMax) w_level_nxt = r_level + 1'b1;
        ST_DOWN: if (r_level > target) w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_tick     <= 1'b0;
      r_level    <= '0;
      r_peak_val <= '0;
      r_hold_cnt <= '0;
      r_state    <= ST_IDLE;
    end else begin
      r_div_cnt <= (r_div_cnt == DivLast) ? '0 : r_div_cnt + 1'b1;
      r_tick    <= (r_div_cnt == DivLast);
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      if (r_tick) begin
        if (w_level_nxt >= r_peak_val) begin
          r_peak_val <= w_level_nxt;
          r_hold_cnt <= HoldInit;
        end else if (r_hold_cnt != '0) begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end else begin
          r_peak_val <= r_peak_val - 1'b1;
        end
      end
    end
  end

  always_comb begin
    bar  = '0;
    peak = '0;
    for (int i = 0; i < int'(W); i++) begin
      bar[i]  = (i < int'(r_level));
      peak[i] = (r_peak_val != '0) && (int'(r_peak_val) == i + 1);
    end
  end

  assign level = r_level;
  assign busy  = (r_level != target);
  assign tick  = r_tick;

endmodule
